// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic operation unit: opSel encodings and the
// field widths of one output-queue entry {result, op, err}.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND     = 2'b00,
    OP_OR      = 2'b01,
    OP_XOR     = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned ERR_W  = 1;
  localparam int unsigned META_W = OP_W + ERR_W;

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/logic_op_unit_if.sv
// Beat-in / result-out bus of the logic operation unit.
// master = producer/consumer side, slave = the unit itself.
interface logic_op_unit_if
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic [OP_W-1:0]  opSel;
  logic             accMode;
  logic             last;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] out;
  logic [OP_W-1:0]  outOp;
  logic             outErr;

  modport master (
    output inValid, aIn, bIn, opSel, accMode, last, outReady,
    input  inReady, outValid, out, outOp, outErr
  );

  modport slave (
    input  inValid, aIn, bIn, opSel, accMode, last, outReady,
    output inReady, outValid, out, outOp, outErr
  );
endinterface

// File: rtl/logic_op_fifo.sv
// Count-based circular output queue. A push is refused while full even if a
// pop happens in the same cycle. data_o shows the head entry, zero when empty.
module logic_op_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer/count values from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/logic_op_unit.sv
// Bitwise AND/OR/XOR unit with a DEPTH-entry result queue.
// Optional feature macro: LOGIC_OP_UNIT_ACC_EN enables multi-beat
// accumulation (accMode/last); without it every accepted beat is pushed.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  logic_op_unit_if.slave  bus
);
  localparam int unsigned ENTRY_W = WIDTH + META_W;

  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   r;
  logic               r_err;
  logic               push;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;

  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [OP_W-1:0]  op);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return '0;
    endcase
  endfunction

  // inReady depends only on the registered occupancy.
  assign in_ready    = !fifo_full;
  assign bus.inReady = in_ready;
  assign accept      = bus.inValid && in_ready && !rst;

  // Per-beat result and error flag.
  always_comb begin
    r     = apply_op(bus.aIn, bus.bIn, bus.opSel);
    r_err = is_illegal(bus.opSel);
  end

`ifdef LOGIC_OP_UNIT_ACC_EN
  logic             acc_active_q, acc_active_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] acc_new;
  logic             err_new;

  // Accumulator update and push decision; non-acc beats pass straight
  // through without disturbing an open accumulation sequence.
  always_comb begin
    acc_active_d = acc_active_q;
    acc_d        = acc_q;
    sticky_d     = sticky_q;
    push         = 1'b0;
    entry        = {r, bus.opSel, r_err};
    acc_new      = r;
    err_new      = r_err;
    if (accept) begin
      if (!bus.accMode) begin
        push = 1'b1;
      end else begin
        if (acc_active_q) begin
          acc_new = r_err ? acc_q : apply_op(acc_q, r, bus.opSel);
          err_new = sticky_q | r_err;
        end
        if (bus.last) begin
          push         = 1'b1;
          entry        = {acc_new, bus.opSel, err_new};
          acc_active_d = 1'b0;
          acc_d        = '0;
          sticky_d     = 1'b0;
        end else begin
          acc_active_d = 1'b1;
          acc_d        = acc_new;
          sticky_d     = err_new;
        end
      end
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_active_q <= 1'b0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
    end else begin
      acc_active_q <= acc_active_d;
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
    end
  end
`else
  // Every accepted beat produces a result entry.
  always_comb begin
    push  = accept;
    entry = {r, bus.opSel, r_err};
  end
`endif

  logic_op_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (bus.outReady),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.outValid = !fifo_empty;
  assign bus.out      = head[ENTRY_W-1 -: WIDTH];
  assign bus.outOp    = head[META_W-1 -: OP_W];
  assign bus.outErr   = head[0];

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed bench for logic_op_unit (WIDTH=4, DEPTH=2).
module tb_logic_op_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  logic_op_unit_if #(.WIDTH(4)) bus ();

  logic_op_unit #(.WIDTH(4), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       acc;
    logic       lst;
    logic [3:0] eo;
    logic [1:0] eop;
    logic       eerr;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic acc, input logic lst);
    bus.inValid = 1'b1;
    bus.aIn     = a;
    bus.bIn     = b;
    bus.opSel   = op;
    bus.accMode = acc;
    bus.last    = lst;
  endtask

  task automatic check_out(input string nm, input logic v, input logic [3:0] o,
                           input logic [1:0] op, input logic err);
    check({nm, ".outValid"}, 32'(bus.outValid), 32'(v));
    check({nm, ".out"},      32'(bus.out),      32'(o));
    check({nm, ".outOp"},    32'(bus.outOp),    32'(op));
    check({nm, ".outErr"},   32'(bus.outErr),   32'(err));
  endtask

  initial begin
    vecs[0] = '{"and",      4'b1100, 4'b1010, 2'b00, 1'b0, 1'b0, 4'b1000, 2'b00, 1'b0};
    vecs[1] = '{"or",       4'b1100, 4'b1010, 2'b01, 1'b0, 1'b0, 4'b1110, 2'b01, 1'b0};
    vecs[2] = '{"xor",      4'b1100, 4'b1010, 2'b10, 1'b0, 1'b0, 4'b0110, 2'b10, 1'b0};
    vecs[3] = '{"ill_ff",   4'b1111, 4'b1111, 2'b11, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1};
    vecs[4] = '{"and_zero", 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0};
    vecs[5] = '{"or_ones",  4'b1000, 4'b0111, 2'b01, 1'b0, 1'b0, 4'b1111, 2'b01, 1'b0};
    vecs[6] = '{"xor_alt",  4'b1010, 4'b0101, 2'b10, 1'b0, 1'b0, 4'b1111, 2'b10, 1'b0};
    vecs[7] = '{"last_ign", 4'b0111, 4'b1110, 2'b00, 1'b0, 1'b1, 4'b0110, 2'b00, 1'b0};
    vecs[8] = '{"ill_mix",  4'b0101, 4'b0011, 2'b11, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1};

    rst          = 1'b1;
    bus.inValid  = 1'b0;
    bus.aIn      = '0;
    bus.bIn      = '0;
    bus.opSel    = '0;
    bus.accMode  = 1'b0;
    bus.last     = 1'b0;
    bus.outReady = 1'b1;
    @(negedge clk);
    cyc();
    cyc();
    check("reset.inReady", 32'(bus.inReady), 32'd1);
    check_out("reset", 1'b0, 4'd0, 2'd0, 1'b0);
    rst = 1'b0;
    cyc();

    // single beats, one result each, drained immediately
    for (int i = 0; i < 9; i++) begin
      check({vecs[i].name, ".inReady"}, 32'(bus.inReady), 32'd1);
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].acc, vecs[i].lst);
      cyc();
      bus.inValid = 1'b0;
      check_out(vecs[i].name, 1'b1, vecs[i].eo, vecs[i].eop, vecs[i].eerr);
      cyc();
      check({vecs[i].name, ".drained"}, 32'(bus.outValid), 32'd0);
    end

    // backpressure: fill both entries, third beat waits, FIFO order kept
    bus.outReady = 1'b0;
    drive(4'b1111, 4'b0011, 2'b00, 1'b0, 1'b0);
    cyc();
    check("bp.ready1", 32'(bus.inReady), 32'd1);
    check_out("bp.head1", 1'b1, 4'b0011, 2'b00, 1'b0);
    drive(4'b0001, 4'b0100, 2'b01, 1'b0, 1'b0);
    cyc();
    check("bp.full", 32'(bus.inReady), 32'd0);
    drive(4'b1111, 4'b0001, 2'b10, 1'b0, 1'b0);
    cyc();
    check("bp.stillfull", 32'(bus.inReady), 32'd0);
    check_out("bp.hold", 1'b1, 4'b0011, 2'b00, 1'b0);
    bus.outReady = 1'b1;
    cyc();
    check("bp.ready_after_pop", 32'(bus.inReady), 32'd1);
    check_out("bp.second", 1'b1, 4'b0101, 2'b01, 1'b0);
    cyc();
    bus.inValid = 1'b0;
    check_out("bp.third", 1'b1, 4'b1110, 2'b10, 1'b0);
    cyc();
    check("bp.empty", 32'(bus.outValid), 32'd0);

    // reset with one queued entry; beat presented during reset is dropped
    bus.outReady = 1'b0;
    drive(4'b1001, 4'b1001, 2'b00, 1'b0, 1'b0);
    cyc();
    check("rst.queued", 32'(bus.outValid), 32'd1);
    drive(4'b1111, 4'b1111, 2'b01, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    check("rst.inReady", 32'(bus.inReady), 32'd1);
    check_out("rst.cleared", 1'b0, 4'd0, 2'd0, 1'b0);
    rst = 1'b0;
    bus.inValid = 1'b0;
    cyc();
    check("rst.dropped", 32'(bus.outValid), 32'd0);
    bus.outReady = 1'b1;

`ifndef LOGIC_OP_UNIT_ACC_EN
    // accMode/last have no effect without the accumulation feature
    drive(4'b1010, 4'b1010, 2'b00, 1'b1, 1'b0);
    cyc();
    bus.inValid = 1'b0;
    check_out("noacc", 1'b1, 4'b1010, 2'b00, 1'b0);
    cyc();
    check("noacc.drained", 32'(bus.outValid), 32'd0);
`else
    // two-beat accumulation: (1111&1100) | (0011|0011) = 1111
    drive(4'b1111, 4'b1100, 2'b00, 1'b1, 1'b0);
    cyc();
    check("acc.nopush", 32'(bus.outValid), 32'd0);
    drive(4'b0011, 4'b0011, 2'b01, 1'b1, 1'b1);
    cyc();
    bus.inValid = 1'b0;
    check_out("acc.final", 1'b1, 4'b1111, 2'b01, 1'b0);
    cyc();
    check("acc.single", 32'(bus.outValid), 32'd0);

    // illegal mid-sequence: acc unchanged, sticky error reported at the end
    drive(4'b0001, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc();
    drive(4'b1111, 4'b1111, 2'b11, 1'b1, 1'b0);
    cyc();
    check("accill.nopush", 32'(bus.outValid), 32'd0);
    drive(4'b0001, 4'b0000, 2'b10, 1'b1, 1'b1);
    cyc();
    bus.inValid = 1'b0;
    check_out("accill.final", 1'b1, 4'b0010, 2'b10, 1'b1);
    cyc();

    // reset mid-accumulation abandons the open sequence
    bus.outReady = 1'b0;
    drive(4'b0101, 4'b0101, 2'b00, 1'b0, 1'b0);
    cyc();
    drive(4'b1001, 4'b0000, 2'b10, 1'b1, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("accrst.inReady", 32'(bus.inReady), 32'd1);
    check_out("accrst.cleared", 1'b0, 4'd0, 2'd0, 1'b0);
    drive(4'b0110, 4'b0111, 2'b00, 1'b1, 1'b1);
    cyc();
    bus.inValid = 1'b0;
    check_out("accrst.newseq", 1'b1, 4'b0110, 2'b00, 1'b0);
    bus.outReady = 1'b1;
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_op_unit.md
LOGIC_OP_UNIT -- requirements
Module: logic_op_unit

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result bit width (>=1).
REQ-002 Parameter: DEPTH, default 2, output FIFO entries (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inValid  input  1  input beat valid.
REQ-006 inReady  output  1  unit can accept a beat.
REQ-007 aIn  input  WIDTH  operand A.
REQ-008 bIn  input  WIDTH  operand B.
REQ-009 opSel  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 illegal.
REQ-010 accMode  input  1  beat belongs to an accumulation sequence.
REQ-011 last  input  1  final beat of an accumulation sequence.
REQ-012 outValid  output  1  result available.
REQ-013 outReady  input  1  consumer takes result.
REQ-014 out  output  WIDTH  result.
REQ-015 outOp  output  2  opSel of the beat that produced the result.
REQ-016 outErr  output  1  illegal opSel was seen in the result's beat(s).

Function
REQ-017 Input handshake SHALL complete when inValid && inReady on a rising edge; output when outValid && outReady.
REQ-018 inReady SHALL equal (FIFO count < DEPTH), from registered state only, with no combinational path from outReady.
REQ-019 Per-beat result r: AND -> aIn&bIn, OR -> aIn|bIn, XOR -> aIn^bIn, illegal -> all-zero with error bit 1.
REQ-020 Non-accumulating accepted beat (accMode=0): push {r, opSel, err} into FIFO; outValid rises exactly one cycle after the accepting edge if FIFO was empty.
REQ-021 Accumulation: first accMode beat loads acc=r; each later accMode beat sets acc = acc OP r using that beat's opSel; illegal opSel leaves acc unchanged and sets sticky error.
REQ-022 An accMode beat with last=1 SHALL push {final acc, its opSel, sticky error} and clear acc state; accMode beats with last=0 SHALL NOT push.
REQ-023 last with accMode=0 SHALL be ignored.
REQ-024 FIFO SHALL be first-in first-out; out/outOp/outErr driven from head entry; hold stable while outValid && !outReady.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; when full, no push is possible that cycle even if a pop occurs.
REQ-026 When FIFO empty: outValid=0, out/outOp/outErr = 0.
REQ-027 Result width SHALL equal WIDTH exactly; no carry or extension.

Reset
REQ-028 rst=1 SHALL on the next edge empty the FIFO, clear acc and sticky error, abandon any partial accumulation sequence.
REQ-029 Post-reset values: inReady=1 (registered state reset), outValid=0, out=0, outOp=00, outErr=0.
REQ-030 Beats presented while rst=1 SHALL be dropped.

Configuration
REQ-031 Macro LOGIC_OP_UNIT_ACC_EN: defined -> accumulation per REQ-021..023.
REQ-032 Not defined -> no acc/sticky registers built; accMode and last ignored; every accepted beat pushes per REQ-020.

Structure
REQ-033 Package logic_op_pkg SHALL hold opSel encodings (OP_AND, OP_OR, OP_XOR, OP_ILLEGAL) and the FIFO entry field widths.
REQ-034 Sub-module logic_op_fifo (parameters WIDTH+3, DEPTH) SHALL implement the output queue with count-based full/empty.

Verification
REQ-035 WIDTH=4: aIn=1100, bIn=1010, opSel=10, accMode=0, outReady=1 -> next cycle outValid=1, out=0110, outOp=10, outErr=0.
REQ-036 opSel=11, aIn=1111, bIn=1111 -> out=0000, outErr=1, outOp=11.
REQ-037 ACC_EN: beats (1111&1100 AND, then 0011 OR with bIn=0011, last=1) -> single result out=1111, no result after first beat.
REQ-038 DEPTH=2, outReady=0, three beats offered -> two accepted, inReady=0 after second; outReady=1 -> results emerge in order, third beat then accepted.
REQ-039 rst asserted mid-accumulation with FIFO holding one entry -> next cycle outValid=0, out=0, inReady=1; subsequent accMode beat starts a new sequence.
REQ-040 ACC_EN not defined: accMode=1, last=0, AND of 1010/1010 -> result 1010 emitted next cycle.
